// File: rtl/fwd_hazard_if.sv
// Forwarding/hazard unit bus: ID-stage instruction fields and pipeline controls in,
// forward selects, the load-use stall and the stall counter out.
interface fwd_hazard_if #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    logic                        forward_en;
    logic                        freeze;
    logic                        flush;
    logic                        id_valid;
    logic [NUM_SRC*ADDR_W-1:0]   id_src;
    logic [NUM_SRC-1:0]          id_src_valid;
    logic                        id_wb_en;
    logic [ADDR_W-1:0]           id_dest;
    logic                        id_is_load;
    logic                        hazard_stall;
    logic [NUM_SRC*SEL_W-1:0]    sel_src;
    logic [CNT_W-1:0]            stall_count;

    modport master (
        output forward_en, freeze, flush, id_valid, id_src, id_src_valid,
               id_wb_en, id_dest, id_is_load,
        input  hazard_stall, sel_src, stall_count
    );

    modport slave (
        input  forward_en, freeze, flush, id_valid, id_src, id_src_valid,
               id_wb_en, id_dest, id_is_load,
        output hazard_stall, sel_src, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Shadow pipeline of in-flight writers (EXE + DEPTH post-EXE stages) driving EXE
// operand forward selects, the ID load-use / no-forward stall and a stall counter.
module fwd_hazard_unit #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    fwd_hazard_if.slave  bus
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    // Index 0 is the EXE entry, index k is post-EXE stage k.
    logic                ent_valid [DEPTH+1];
    logic                ent_wb_en [DEPTH+1];
    logic [ADDR_W-1:0]   ent_dest  [DEPTH+1];
    logic                ent_load  [DEPTH+1];
    logic [ADDR_W-1:0]   exe_src   [NUM_SRC];
    logic [NUM_SRC-1:0]  exe_src_valid;
    logic [CNT_W-1:0]    stall_cnt;

    logic                        stall_c;
    logic                        issue_c;
    logic [NUM_SRC*SEL_W-1:0]    sel_c;

    assign issue_c = bus.id_valid && !stall_c && !bus.flush;

    // Shadow pipeline advance; a frozen pipeline holds every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k <= DEPTH; k++) begin
                ent_valid[k] <= 1'b0;
                ent_wb_en[k] <= 1'b0;
                ent_dest[k]  <= '0;
                ent_load[k]  <= 1'b0;
            end
            for (int unsigned i = 0; i < NUM_SRC; i++) exe_src[i] <= '0;
            exe_src_valid <= '0;
        end else if (!bus.freeze) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_wb_en[k] <= ent_wb_en[k-1];
                ent_dest[k]  <= ent_dest[k-1];
                ent_load[k]  <= ent_load[k-1];
            end
            ent_valid[0] <= issue_c;
            ent_wb_en[0] <= issue_c && bus.id_wb_en;
            ent_dest[0]  <= issue_c ? bus.id_dest : '0;
            ent_load[0]  <= issue_c && bus.id_is_load;
            for (int unsigned i = 0; i < NUM_SRC; i++)
                exe_src[i] <= issue_c ? bus.id_src[i*ADDR_W +: ADDR_W] : '0;
            exe_src_valid <= issue_c ? bus.id_src_valid : '0;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!bus.freeze && stall_c && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Forward select: nearest post-EXE stage writing each EXE source.
    always_comb begin
        logic [SEL_W-1:0] sel_i;
        sel_c = '0;
        sel_i = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            sel_i = '0;
            if (bus.forward_en && exe_src_valid[i]) begin
                for (int unsigned k = 1; k <= DEPTH; k++) begin
                    if (sel_i == '0 && ent_valid[k] && ent_wb_en[k] &&
                        ent_dest[k] == exe_src[i])
                        sel_i = SEL_W'(k);
                end
            end
            sel_c[i*SEL_W +: SEL_W] = sel_i;
        end
    end

    // ID stall: unready nearest load when forwarding, any non-retiring writer otherwise.
    always_comb begin
        logic [ADDR_W-1:0] src;
        logic              found;
        logic              hit;
        stall_c = 1'b0;
        src     = '0;
        found   = 1'b0;
        hit     = 1'b0;
        if (bus.id_valid && !bus.flush) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                src   = bus.id_src[i*ADDR_W +: ADDR_W];
                found = 1'b0;
                for (int unsigned k = 0; k <= DEPTH; k++) begin
                    hit = bus.id_src_valid[i] && ent_valid[k] && ent_wb_en[k] &&
                          ent_dest[k] == src;
                    if (bus.forward_en) begin
                        if (hit && !found) begin
                            found = 1'b1;
                            if (ent_load[k] && (k + 1 < LOAD_READY)) stall_c = 1'b1;
                        end
                    end else if (hit && k < DEPTH) begin
                        stall_c = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.hazard_stall = stall_c;
    assign bus.sel_src      = sel_c;
    assign bus.stall_count  = stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus random traffic against a
// history-queue model of in-flight instructions.
module tb_fwd_hazard_unit;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned LOAD_READY = 2;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_hazard_if #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    fwd_hazard_unit #(
        .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
        .LOAD_READY(LOAD_READY), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic                      v;
        logic                      wb;
        logic                      ld;
        logic [ADDR_W-1:0]         dest;
        logic [NUM_SRC*ADDR_W-1:0] src;
        logic [NUM_SRC-1:0]        sv;
    } slot_t;

    // hist[0] is the instruction in EXE, hist[p] the one p cycles older.
    slot_t       hist[$];
    int unsigned m_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic writes(input slot_t e, input logic [ADDR_W-1:0] a);
        return e.v && e.wb && (e.dest == a);
    endfunction

    function automatic logic m_stall();
        logic [ADDR_W-1:0] a;
        logic              done;
        if (!bus.id_valid || bus.flush) return 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (bus.id_src_valid[s]) begin
                a    = bus.id_src[s*ADDR_W +: ADDR_W];
                done = 1'b0;
                for (int p = 0; p <= DEPTH; p++) begin
                    if (!done && writes(hist[p], a)) begin
                        if (bus.forward_en) begin
                            done = 1'b1;
                            if (hist[p].ld && (p + 1 < LOAD_READY)) return 1'b1;
                        end else if (p < DEPTH) begin
                            return 1'b1;
                        end
                    end
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [NUM_SRC*SEL_W-1:0] m_sel();
        logic [NUM_SRC*SEL_W-1:0] r;
        logic [ADDR_W-1:0]        a;
        r = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            a = hist[0].src[s*ADDR_W +: ADDR_W];
            if (bus.forward_en && hist[0].v && hist[0].sv[s]) begin
                for (int p = DEPTH; p >= 1; p--)
                    if (writes(hist[p], a)) r[s*SEL_W +: SEL_W] = SEL_W'(p);
            end
        end
        return r;
    endfunction

    function automatic logic [SEL_W-1:0] sel_of(input int s);
        logic [NUM_SRC*SEL_W-1:0] v;
        v = bus.sel_src;
        return v[s*SEL_W +: SEL_W];
    endfunction

    task automatic m_reset();
        hist.delete();
        for (int p = 0; p <= DEPTH; p++) hist.push_back('0);
        m_cnt = 0;
    endtask

    task automatic m_update(input logic st);
        slot_t e;
        if (rst) begin
            m_reset();
        end else if (!bus.freeze) begin
            if (st && m_cnt < CNT_MAX) m_cnt++;
            e = '0;
            if (bus.id_valid && !st && !bus.flush) begin
                e.v    = 1'b1;
                e.wb   = bus.id_wb_en;
                e.ld   = bus.id_is_load;
                e.dest = bus.id_dest;
                e.src  = bus.id_src;
                e.sv   = bus.id_src_valid;
            end
            hist.push_front(e);
            void'(hist.pop_back());
        end
    endtask

    // One clock: compare all outputs against the model, then advance both.
    task automatic cycle();
        logic                     es;
        logic [NUM_SRC*SEL_W-1:0] esel;
        @(negedge clk);
        es   = m_stall();
        esel = m_sel();
        check("hazard_stall", 32'(bus.hazard_stall), 32'(es));
        check("sel_src", 32'(bus.sel_src), 32'(esel));
        check("stall_count", 32'(bus.stall_count), 32'(m_cnt));
        @(posedge clk);
        m_update(es);
        #1;
    endtask

    task automatic set_ctl(input logic fe, input logic frz, input logic fl);
        bus.forward_en = fe;
        bus.freeze     = frz;
        bus.flush      = fl;
    endtask

    task automatic set_id(input logic v, input logic [NUM_SRC*ADDR_W-1:0] src,
                          input logic [NUM_SRC-1:0] sv, input logic wb,
                          input logic [ADDR_W-1:0] dest, input logic ld);
        bus.id_valid     = v;
        bus.id_src       = src;
        bus.id_src_valid = sv;
        bus.id_wb_en     = wb;
        bus.id_dest      = dest;
        bus.id_is_load   = ld;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    logic fe_r;

    initial begin
        rst = 1'b1;
        set_ctl(1'b1, 1'b0, 1'b0);
        set_id(1'b0, '0, '0, 1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
        #1;
        check("rst_stall", 32'(bus.hazard_stall), 32'd0);
        check("rst_sel", 32'(bus.sel_src), 32'd0);
        check("rst_count", 32'(bus.stall_count), 32'd0);

        // Nearest writer wins: ADD r3, SUB r3, consumer of r3.
        set_id(1'b1, '0, 2'b00, 1'b1, 4'd3, 1'b0); cycle();
        set_id(1'b1, '0, 2'b00, 1'b1, 4'd3, 1'b0); cycle();
        set_id(1'b1, 8'h03, 2'b01, 1'b0, 4'd0, 1'b0); cycle();
        set_id(1'b0, '0, '0, 1'b0, '0, 1'b0); #1;
        check("prio_sel0", 32'(sel_of(0)), 32'd1);
        cycle();

        // Load-use: one stall cycle, then forward from stage 2.
        pulse_reset();
        set_id(1'b1, '0, 2'b00, 1'b1, 4'd5, 1'b1); cycle();
        set_id(1'b1, 8'h50, 2'b10, 1'b0, 4'd0, 1'b0); #1;
        check("lu_stall", 32'(bus.hazard_stall), 32'd1);
        cycle(); #1;
        check("lu_release", 32'(bus.hazard_stall), 32'd0);
        cycle();
        set_id(1'b0, '0, '0, 1'b0, '0, 1'b0); #1;
        check("lu_sel1", 32'(sel_of(1)), 32'd2);
        check("lu_count", 32'(bus.stall_count), 32'd1);
        cycle();

        // Load shadowed by a nearer ALU writer.
        pulse_reset();
        set_id(1'b1, '0, 2'b00, 1'b1, 4'd5, 1'b1); cycle();
        set_id(1'b1, '0, 2'b00, 1'b1, 4'd5, 1'b0); cycle();
        set_id(1'b1, 8'h05, 2'b01, 1'b0, 4'd0, 1'b0); #1;
        check("shadow_stall", 32'(bus.hazard_stall), 32'd0);
        cycle();
        set_id(1'b0, '0, '0, 1'b0, '0, 1'b0); #1;
        check("shadow_sel0", 32'(sel_of(0)), 32'd1);
        cycle();

        // No-forward mode: stall for DEPTH cycles, selects stay 0.
        pulse_reset();
        set_ctl(1'b0, 1'b0, 1'b0);
        set_id(1'b1, '0, 2'b00, 1'b1, 4'd2, 1'b0); cycle();
        set_id(1'b1, 8'h02, 2'b01, 1'b0, 4'd0, 1'b0); #1;
        check("nofwd_stall_a", 32'(bus.hazard_stall), 32'd1);
        cycle(); #1;
        check("nofwd_stall_b", 32'(bus.hazard_stall), 32'd1);
        cycle(); #1;
        check("nofwd_release", 32'(bus.hazard_stall), 32'd0);
        cycle();
        set_id(1'b0, '0, '0, 1'b0, '0, 1'b0); #1;
        check("nofwd_sel", 32'(bus.sel_src), 32'd0);
        check("nofwd_count", 32'(bus.stall_count), 32'd2);
        cycle();
        set_ctl(1'b1, 1'b0, 1'b0);

        // Freeze during a load-use stall holds state and the counter.
        pulse_reset();
        set_id(1'b1, '0, 2'b00, 1'b1, 4'd5, 1'b1); cycle();
        set_id(1'b1, 8'h50, 2'b10, 1'b0, 4'd0, 1'b0);
        set_ctl(1'b1, 1'b1, 1'b0);
        repeat (3) cycle();
        #1;
        check("frz_stall", 32'(bus.hazard_stall), 32'd1);
        check("frz_count", 32'(bus.stall_count), 32'd0);
        set_ctl(1'b1, 1'b0, 1'b0);
        cycle(); #1;
        check("frz_count_after", 32'(bus.stall_count), 32'd1);
        cycle();

        // Flush beats a pending load-use hazard and inserts a bubble.
        pulse_reset();
        set_id(1'b1, '0, 2'b00, 1'b1, 4'd5, 1'b1); cycle();
        set_id(1'b1, 8'h05, 2'b01, 1'b0, 4'd0, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b1); #1;
        check("flush_stall", 32'(bus.hazard_stall), 32'd0);
        cycle();
        set_ctl(1'b1, 1'b0, 1'b0);
        set_id(1'b0, '0, '0, 1'b0, '0, 1'b0); #1;
        check("flush_count", 32'(bus.stall_count), 32'd0);
        check("flush_bubble_sel", 32'(bus.sel_src), 32'd0);
        cycle();

        // Counter saturation over 20 stall cycles, then reset clears it.
        pulse_reset();
        set_ctl(1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 10; r++) begin
            set_id(1'b1, '0, 2'b00, 1'b1, 4'd7, 1'b0); cycle();
            set_id(1'b1, 8'h07, 2'b01, 1'b0, 4'd0, 1'b0);
            repeat (3) cycle();
        end
        #1;
        check("sat_count", 32'(bus.stall_count), 32'(CNT_MAX));
        set_id(1'b1, '0, 2'b00, 1'b1, 4'd7, 1'b0); cycle();
        set_id(1'b1, 8'h07, 2'b01, 1'b0, 4'd0, 1'b0);
        pulse_reset(); #1;
        check("post_rst_count", 32'(bus.stall_count), 32'd0);
        check("post_rst_sel", 32'(bus.sel_src), 32'd0);
        check("post_rst_stall", 32'(bus.hazard_stall), 32'd0);
        set_ctl(1'b1, 1'b0, 1'b0);

        // Random traffic over a small register window to force frequent matches.
        fe_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) fe_r = ~fe_r;
            set_ctl(fe_r, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 4) != 0,
                   {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                   2'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0,
                   4'($urandom_range(0, 3)),
                   $urandom_range(0, 2) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
